// File: rtl/ula_pkg.sv
// Shared op-code constants and FSM state type for the execute-stage ALU.
// The op codes are also consumed by the upstream ALU-op decoder.
package ula_pkg;

    localparam logic [2:0] ULA_ADD   = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_OR    = 3'b010;
    localparam logic [2:0] ULA_EQUAL = 3'b011;
    localparam logic [2:0] ULA_LESS  = 3'b100;
    localparam logic [2:0] ULA_MULT  = 3'b101;
    localparam logic [2:0] ULA_DIV   = 3'b110;
    localparam logic [2:0] ULA_AND   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == ULA_MULT) || (op == ULA_DIV);
    endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// Unsigned magnitude engine: shift-add multiplier or restoring divider, one bit per cycle.
// After WIDTH steps hi_mag/lo_mag hold {product} or {remainder, quotient}.
module ula_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             step_done,
    output logic [WIDTH-1:0] hi_mag,
    output logic [WIDTH-1:0] lo_mag
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shifted;
    logic [WIDTH:0]   w_div_trial;

    always_comb begin
        w_mul_sum     = {1'b0, r_acc} + (r_shift[0] ? {1'b0, r_b} : '0);
        w_div_shifted = {r_acc, r_shift[WIDTH-1]};
        // A set top bit means the trial subtraction borrowed: keep the shifted remainder.
        w_div_trial   = w_div_shifted - {1'b0, r_b};
    end

    assign step_done = r_active && (r_cnt == LAST_STEP);
    assign hi_mag    = r_acc;
    assign lo_mag    = r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (load) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (r_active) begin
            if (r_cnt == LAST_STEP) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            r_is_div <= is_div;
            r_b      <= b_mag;
            r_acc    <= '0;
            r_shift  <= a_mag;
        end else if (r_active) begin
            if (r_is_div) begin
                r_acc   <= w_div_trial[WIDTH] ? w_div_shifted[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
                r_shift <= {r_shift[WIDTH-2:0], ~w_div_trial[WIDTH]};
            end else begin
                r_acc   <= w_mul_sum[WIDTH:1];
                r_shift <= {w_mul_sum[0], r_shift[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/ula_exec_multicycle.sv
// Execute-stage ALU: single-cycle ops plus signed iterative Mult/Div owning HI/LO.
// Handshakes with the control FSM through start/busy/done.
module ula_exec_multicycle
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t r_state;
    logic   r_is_div;
    logic   r_neg_lo;
    logic   r_neg_hi;

    logic                    w_accept;
    logic                    w_div_by_zero;
    logic                    w_load;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic [WIDTH-1:0]        w_single_res;
    logic [WIDTH-1:0]        w_a_mag;
    logic [WIDTH-1:0]        w_b_mag;
    logic                    w_step_done;
    logic [WIDTH-1:0]        w_hi_mag;
    logic [WIDTH-1:0]        w_lo_mag;
    logic [2*WIDTH-1:0]      w_prod_fix;
    logic [WIDTH-1:0]        w_quot_fix;
    logic [WIDTH-1:0]        w_rem_fix;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign w_accept      = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_div_by_zero = (op == ULA_DIV) && (b == '0);
    assign w_load        = w_accept && is_multicycle(op) && !w_div_by_zero;
    assign w_a_s         = a;
    assign w_b_s         = b;
    assign w_a_mag       = f_mag(a);
    assign w_b_mag       = f_mag(b);

    always_comb begin
        w_single_res = '0;
        case (op)
            ULA_ADD:   w_single_res = a + b;
            ULA_SUB:   w_single_res = a - b;
            ULA_OR:    w_single_res = a | b;
            ULA_EQUAL: w_single_res = WIDTH'(a == b);
            ULA_LESS:  w_single_res = WIDTH'(w_a_s < w_b_s);
            ULA_AND:   w_single_res = a & b;
            default:   w_single_res = '0;
        endcase
    end

    // Sign fix-up applied in SIGN: product/quotient by sign xor, remainder by dividend sign.
    assign w_prod_fix = f_cneg2({w_hi_mag, w_lo_mag}, r_neg_lo);
    assign w_quot_fix = f_cneg(w_lo_mag, r_neg_lo);
    assign w_rem_fix  = f_cneg(w_hi_mag, r_neg_hi);

    ula_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .is_div    (op == ULA_DIV),
        .a_mag     (w_a_mag),
        .b_mag     (w_b_mag),
        .step_done (w_step_done),
        .hi_mag    (w_hi_mag),
        .lo_mag    (w_lo_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    if (w_accept && w_load) begin
                        r_is_div <= (op == ULA_DIV);
                        r_neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_hi <= a[WIDTH-1];
                        busy     <= 1'b1;
                        r_state  <= ITER;
                    end else if (w_accept && w_div_by_zero) begin
                        lo      <= '1;
                        hi      <= a;
                        result  <= '1;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else if (w_accept) begin
                        result <= w_single_res;
                        if (op == ULA_EQUAL) begin
                            zero <= (a == b);
                        end
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ITER: begin
                    if (w_step_done) begin
                        r_state <= SIGN;
                    end
                end
                SIGN: begin
                    if (r_is_div) begin
                        lo     <= w_quot_fix;
                        hi     <= w_rem_fix;
                        result <= w_quot_fix;
                    end else begin
                        hi     <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo     <= w_prod_fix[WIDTH-1:0];
                        result <= w_prod_fix[WIDTH-1:0];
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_exec_multicycle.sv
// Directed bench for ula_exec_multicycle with hand-computed expected values.
module tb_ula_exec_multicycle;
    import ula_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total;
    int n_bad;
    int lat;
    logic sbusy;
    int done_seen;

    ula_exec_multicycle #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op; optionally pulse an Add start after edge 'inj' to probe busy-time ignoring.
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input int inj, output int t_lat, output logic t_sbusy);
        int n;
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        n = 0; t_sbusy = 1'b0; t_lat = -1;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            start = (n == inj);
            if (n == inj) begin
                op = ULA_ADD; a = 32'h1; b = 32'h1;
            end
            t_sbusy = t_sbusy | busy;
            if (done) begin
                t_lat = n;
                break;
            end
        end
        if (t_lat < 0) chk("timeout_done", {63'b0, done}, 64'd1);
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; op = ULA_ADD; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {63'b0, busy}, 64'd0);
        chk("rst_done",   {63'b0, done}, 64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        chk("rst_zero",   {63'b0, zero}, 64'd0);
        chk("rst_hi",     {32'b0, hi}, 64'd0);
        chk("rst_lo",     {32'b0, lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(ULA_ADD, 32'd7, 32'd5, 0, lat, sbusy);
        chk("add_lat",  64'(lat), 64'd1);
        chk("add_res",  {32'b0, result}, 64'd12);
        chk("add_busy", {63'b0, sbusy}, 64'd0);

        run_op(ULA_SUB, 32'd3, 32'd5, 0, lat, sbusy);
        chk("sub_res", {32'b0, result}, 64'hFFFFFFFE);

        run_op(ULA_LESS, 32'hFFFFFFFF, 32'd1, 0, lat, sbusy);
        chk("less_neg", {32'b0, result}, 64'd1);
        run_op(ULA_LESS, 32'd1, 32'hFFFFFFFF, 0, lat, sbusy);
        chk("less_pos", {32'b0, result}, 64'd0);

        run_op(ULA_EQUAL, 32'd9, 32'd9, 0, lat, sbusy);
        chk("eq_zero", {63'b0, zero}, 64'd1);
        chk("eq_res",  {32'b0, result}, 64'd1);
        run_op(ULA_OR, 32'h000000F0, 32'h0000000F, 0, lat, sbusy);
        chk("or_res",  {32'b0, result}, 64'hFF);
        chk("or_zero_kept", {63'b0, zero}, 64'd1);
        run_op(ULA_EQUAL, 32'd9, 32'd8, 0, lat, sbusy);
        chk("neq_zero", {63'b0, zero}, 64'd0);
        run_op(ULA_AND, 32'hFF00FF00, 32'h0FF00FF0, 0, lat, sbusy);
        chk("and_res", {32'b0, result}, 64'h0F000F00);
        chk("single_hilo", {hi, lo}, 64'd0);

        run_op(ULA_MULT, 32'hFFFFFFFD, 32'd100000, 0, lat, sbusy);
        chk("mul_lat",  64'(lat), 64'd34);
        chk("mul_lo",   {32'b0, lo}, 64'hFFFB6C20);
        chk("mul_hi",   {32'b0, hi}, 64'hFFFFFFFF);
        chk("mul_res",  {32'b0, result}, 64'hFFFB6C20);
        chk("mul_busy", {63'b0, sbusy}, 64'd1);

        run_op(ULA_ADD, 32'd1, 32'd2, 0, lat, sbusy);
        chk("add2_res",  {32'b0, result}, 64'd3);
        chk("add2_hilo", {hi, lo}, 64'hFFFFFFFF_FFFB6C20);

        run_op(ULA_DIV, 32'hFFFFFFF9, 32'd2, 0, lat, sbusy);
        chk("div_lat", 64'(lat), 64'd34);
        chk("div_lo",  {32'b0, lo}, 64'hFFFFFFFD);
        chk("div_hi",  {32'b0, hi}, 64'hFFFFFFFF);
        chk("div_res", {32'b0, result}, 64'hFFFFFFFD);

        run_op(ULA_DIV, 32'd7, 32'hFFFFFFFE, 0, lat, sbusy);
        chk("div_nb_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);

        run_op(ULA_DIV, 32'd7, 32'd0, 0, lat, sbusy);
        chk("div0_lat",  64'(lat), 64'd1);
        chk("div0_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
        chk("div0_res",  {32'b0, result}, 64'hFFFFFFFF);
        chk("div0_busy", {63'b0, sbusy}, 64'd0);

        run_op(ULA_DIV, 32'h80000000, 32'hFFFFFFFF, 0, lat, sbusy);
        chk("div_minneg_hilo", {hi, lo}, 64'h00000000_80000000);

        run_op(ULA_MULT, 32'hFFFFFFFB, 32'hFFFFFFFC, 0, lat, sbusy);
        chk("mul_nn_hilo", {hi, lo}, 64'h00000000_00000014);

        run_op(ULA_MULT, 32'd6, 32'd7, 5, lat, sbusy);
        chk("mul_inj_lat",  64'(lat), 64'd34);
        chk("mul_inj_hilo", {hi, lo}, 64'h00000000_0000002A);
        chk("mul_inj_res",  {32'b0, result}, 64'h2A);

        run_op(ULA_DIV, 32'd100, 32'd7, 0, lat, sbusy);
        chk("div_b2b_hilo", {hi, lo}, 64'h00000002_0000000E);
        op = ULA_ADD; a = 32'd10; b = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done", {63'b0, done}, 64'd1);
        chk("b2b_res",  {32'b0, result}, 64'd30);
        chk("b2b_hilo", {hi, lo}, 64'h00000002_0000000E);
        @(posedge clk); #1;
        chk("b2b_done_drop", {63'b0, done}, 64'd0);

        op = ULA_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy_pre", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        chk("mid_rst_res",  {32'b0, result}, 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("mid_no_done", 64'(done_seen), 64'd0);

        run_op(ULA_MULT, 32'd123, 32'hFFFFFFFE, 0, lat, sbusy);
        chk("mul_after_lat",  64'(lat), 64'd34);
        chk("mul_after_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFF0A);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
